// File: rtl/fetch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_pkg
// Description : Shared constants and helpers for the decoupled fetch front
//               end: default data width, reset PC, source-select bit, NOP
//               encoding and the layout/width of a queued fetch entry.
//               Entry layout, MSB to LSB: {pc, pc_plus4, instr}.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_unit_pkg;

    localparam int          c_xlen      = 32;
    localparam logic [31:0] c_reset_pc  = 32'h4000_0000;
    localparam int          c_src_bit   = 30;
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    // Width of one queued entry {pc, pc_plus4, instr} for a given data width.
    function automatic int entry_width(input int xlen);
        return 3 * xlen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_fifo
// Description : Synchronous DEPTH x WIDTH FIFO holding fetched entries.
//               Wrapping read/write pointers, occupancy count, and a flush
//               that empties the queue in one cycle.
// Ports       : clk        - clock
//               rst        - synchronous active-low reset
//               flush      - drop all entries (wins over push/pop)
//               push       - write push_data at the tail
//               push_data  - entry to enqueue
//               pop        - remove the head entry
//               head_data  - current head entry
//               count      - number of occupied entries
//               empty      - count == 0
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign w_do_push = push && (!w_full || w_do_pop);

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (rst && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Decoupled sequential fetch front end. Issues reads to a
//               1-cycle synchronous IMEM/BIOS, queues the returned words with
//               their PC and PC+4, and presents the head to decode with a
//               valid/ready handshake. A redirect flushes the queue and kills
//               any read still in flight.
// Ports       : clk, rst (sync active-low)
//               redirect_valid/redirect_pc      - new fetch target
//               imem_en/imem_addr               - read request
//               imem_instr/bios_instr           - read data (next cycle)
//               deq_valid/deq_ready             - decode handshake
//               deq_instr/deq_pc/deq_pc_plus4   - head entry
//               q_count                         - queued entries
// Config      : FETCH_BYPASS_EN - when defined, a response arriving at an
//               empty queue is presented to decode in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int               XLEN     = c_xlen,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = c_reset_pc,
    parameter int               SRC_BIT  = c_src_bit
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    imem_en,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [XLEN-1:0]         imem_instr,
    input  logic [XLEN-1:0]         bios_instr,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [XLEN-1:0]         deq_instr,
    output logic [XLEN-1:0]         deq_pc,
    output logic [XLEN-1:0]         deq_pc_plus4,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int c_entry_w = entry_width(XLEN);

    logic [XLEN-1:0]      r_fetch_pc;
    logic                 r_inflight;
    logic [XLEN-1:0]      r_inflight_pc;
    logic                 r_inflight_src;

    logic [c_entry_w-1:0] w_head;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_out;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_empty;
    logic [XLEN-1:0]      w_resp_instr;
    logic                 w_resp_valid;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_deq_fire;
    logic                 w_issue;
    logic [c_cnt_w:0]     w_credit_used;

    // Response path: the source was latched with the request, so a PC that
    // crosses the source boundary still reads the right memory.
    assign w_resp_instr = r_inflight_src ? bios_instr : imem_instr;
    assign w_resp_valid = rst && r_inflight && !redirect_valid;
    assign w_push_data  = {r_inflight_pc, r_inflight_pc + XLEN'(4), w_resp_instr};

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_resp_valid && w_empty;
    assign deq_valid = (rst && !w_empty) || w_bypass;
    assign w_out     = w_empty ? w_push_data : w_head;
    assign w_pop     = rst && !w_empty && deq_ready;
    // A bypassed word that decode takes immediately never enters the queue.
    assign w_push    = w_resp_valid && !(w_bypass && deq_ready);
`else
    assign deq_valid = rst && !w_empty;
    assign w_out     = w_head;
    assign w_pop     = deq_valid && deq_ready;
    assign w_push    = w_resp_valid;
`endif

    assign w_deq_fire = deq_valid && deq_ready;

    // Credits: queued + in-flight words, minus the one leaving this cycle,
    // must leave room for the word requested now. This is what keeps the
    // queue from ever overflowing, at the cost of a deq_ready->imem_en path.
    assign w_credit_used = {1'b0, w_count}
                         + {{c_cnt_w{1'b0}}, r_inflight}
                         - {{c_cnt_w{1'b0}}, w_deq_fire};
    assign w_issue   = rst && !redirect_valid
                     && (w_credit_used < (c_cnt_w+1)'(DEPTH));

    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;

    assign deq_pc       = deq_valid ? w_out[3*XLEN-1:2*XLEN] : '0;
    assign deq_pc_plus4 = deq_valid ? w_out[2*XLEN-1:XLEN]   : '0;
    // Idle decode sees a NOP rather than stale data, except under reset.
    assign deq_instr    = deq_valid ? w_out[XLEN-1:0]
                        : (rst ? XLEN'(c_nop_instr) : '0);
    assign q_count      = rst ? w_count : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc     <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= '0;
            r_inflight_src <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc     <= redirect_pc & ~XLEN'(3);
            r_inflight     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc  <= r_fetch_pc;
                r_inflight_src <= r_fetch_pc[SRC_BIT];
                r_fetch_pc     <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    fetch_queue_unit_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit. Memories return a
//               hash of the read address; a scoreboard holds the expected
//               sequential {pc, instr} stream from the last reset/redirect
//               target and a negedge monitor checks every dequeue.
// Config      : FETCH_BYPASS_EN (must match the RTL build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] bios_instr;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_plus4;
    logic [2:0]  q_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .bios_instr     (bios_instr),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .deq_pc_plus4   (deq_pc_plus4),
        .q_count        (q_count)
    );

    function automatic logic [31:0] f_imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1357;
    endfunction

    function automatic logic [31:0] f_bios(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // Bit 30 of the address selects BIOS (1) or IMEM (0).
    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return pc[30] ? f_bios(pc) : f_imem(pc);
    endfunction

    // Synchronous memories; unrequested cycles return noise.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_instr <= f_imem(imem_addr);
            bios_instr <= f_bios(imem_addr);
        end else begin
            imem_instr <= $urandom;
            bios_instr <= $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle. The inputs still applied are those of the cycle just
    // completed, so a reset/redirect seen here restarts the expected stream.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            model_pc = RESET_PC;
        end else if (redirect_valid) begin
            sb.delete();
            model_pc = redirect_pc & ~32'd3;
        end
        while (sb.size() < 16) begin
            sb.push_back('{model_pc, exp_instr(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_ready      = rdy;
        #1;
    endtask

    // Monitor: every handshake consumes the next expected entry; a stalled
    // head must stay unchanged.
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    always @(negedge clk) begin
        exp_t e;
        if (hold_v && rst) begin
            check("stall_valid", 32'(deq_valid), 32'd1);
            check("stall_pc", deq_pc, hold_pc);
            check("stall_instr", deq_instr, hold_instr);
        end
        if (deq_valid && deq_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL deq_unexpected: got pc 0x%08h expected no dequeue", deq_pc);
            end else begin
                e = sb.pop_front();
                check("deq_pc", deq_pc, e.pc);
                check("deq_pc_plus4", deq_pc_plus4, e.pc + 32'd4);
                check("deq_instr", deq_instr, e.instr);
            end
        end
        hold_v     = rst && deq_valid && !deq_ready && !redirect_valid;
        hold_pc    = deq_pc;
        hold_instr = deq_instr;
    end

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;

        // 1: reset, then sequential fetch from the BIOS
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("t1_imem_en", 32'(imem_en), 32'd1);
            check("t1_imem_addr", imem_addr, RESET_PC + 32'(4 * (c - 1)));
            check("t1_deq_valid", 32'(deq_valid), 32'(c >= LAT));
            if (c == LAT) check("t1_first_pc", deq_pc, RESET_PC);
        end

        // 2: stalled decode saturates the queue
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            check("t2_imem_en", 32'(imem_en), 32'(c <= DEPTH));
        end
        check("t2_q_full", 32'(q_count), 32'(DEPTH));
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_resume_en", 32'(imem_en), 32'd1);
        check("t2_resume_addr", imem_addr, RESET_PC + 32'h10);
        check("t2_head_pc", deq_pc, RESET_PC);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // 3: redirect from a full queue to an unaligned IMEM target
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t3_full", 32'(q_count), 32'(DEPTH));
        step(1'b1, 1'b1, 32'h1000_0006, 1'b1);
        check("t3_redir_en", 32'(imem_en), 32'd0);
        check("t3_redir_head", 32'(deq_valid), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (k == 1) begin
                check("t3_q_flushed", 32'(q_count), 32'd0);
                check("t3_new_addr", imem_addr, 32'h1000_0004);
            end
            check("t3_deq_valid", 32'(deq_valid), 32'(k >= LAT));
            if (k == LAT) check("t3_first_pc", deq_pc, 32'h1000_0004);
        end
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // 4: three back-to-back redirects, only the last target survives
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        step(1'b1, 1'b1, 32'h4000_0200, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0301, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (k == LAT) check("t4_first_pc", deq_pc, 32'h0000_0300);
        end

        // 5: near-full queue with alternating decode ready
        step(1'b1, 1'b1, 32'h0000_2000, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 32'h0, 1'((c % 2) == 0));
            check("t5_count_range", 32'(q_count >= 3'(DEPTH - 1) && q_count <= 3'(DEPTH)), 32'd1);
        end

        // 6: reset mid-stream with entries queued and a read in flight
        step(1'b1, 1'b1, 32'h0000_4000, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_count3", 32'(q_count), 32'd3);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t6_rst_valid", 32'(deq_valid), 32'd0);
        check("t6_rst_en", 32'(imem_en), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t6_post_valid", 32'(deq_valid), 32'd0);
        check("t6_post_count", 32'(q_count), 32'd0);
        check("t6_post_addr", imem_addr, RESET_PC);
        check("t6_post_en", 32'(imem_en), 32'd1);

        // Random traffic: stalls, redirects anywhere, occasional resets
        for (int c = 0; c < 800; c++) begin
            step(1'($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 99) < 6),
                 $urandom,
                 1'($urandom_range(0, 99) < 70));
        end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
